// File: rtl/data_memory_hs_if.sv
// Request/response bus between the multi-cycle control FSM and data_memory_hs.
// The perr response bit exists only when DMEM_PARITY_EN is defined.
interface data_memory_hs_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req;
  logic             we;
  logic [2:0]       size;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
`ifdef DMEM_PARITY_EN
  logic             perr;

  modport master (output req, we, size, addr, wdata, input ready, done, rdata, err, perr);
  modport slave  (input req, we, size, addr, wdata, output ready, done, rdata, err, perr);
`else
  modport master (output req, we, size, addr, wdata, input ready, done, rdata, err);
  modport slave  (input req, we, size, addr, wdata, output ready, done, rdata, err);
`endif
endinterface

// File: rtl/data_memory_hs.sv
// Word-organised data RAM with req/ready/done handshake, LAT-cycle access latency,
// byte/half/word access with sign/zero extension and illegal-access reporting.
// Optional per-lane even parity with a perr response: define DMEM_PARITY_EN.
// WIDTH must be 32 (four fixed byte lanes).
module data_memory_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned LAT   = 2
) (
  input logic             clk,
  input logic             rst,
  data_memory_hs_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = 4;
  localparam int unsigned NLANE = 4;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       size_q, size_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we_c;
  logic [AW-1:0]    mem_idx_c;
  logic [NLANE-1:0] mem_be_c;
  logic [WIDTH-1:0] mem_wd_c;

  logic [AW-1:0]    idx_c;
  logic [1:0]       off_c;
  logic [WIDTH-1:0] rword_c;
  logic             illegal_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [WIDTH-1:0] load_c;
  logic [NLANE-1:0] st_be_c;
  logic [WIDTH-1:0] st_wd_c;

  assign idx_c   = addr_q[AW+1:2];
  assign off_c   = addr_q[1:0];
  assign rword_c = mem_q[idx_c];

  // Access decode: legality, store lane enables, and load lane extraction
  always_comb begin
    illegal_c = (addr_q >> (AW + 2)) != '0;
    st_be_c   = '0;
    st_wd_c   = wdata_q;
    load_c    = '0;
    byte_c    = rword_c[{off_c, 3'b000} +: 8];
    half_c    = addr_q[1] ? rword_c[31:16] : rword_c[15:0];
    case (size_q)
      3'b000: begin
        st_be_c = NLANE'(1) << off_c;
        st_wd_c = {NLANE{wdata_q[7:0]}};
        load_c  = {{(WIDTH-8){byte_c[7]}}, byte_c};
      end
      3'b001: begin
        illegal_c = illegal_c | addr_q[0];
        st_be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wd_c   = {2{wdata_q[15:0]}};
        load_c    = {{(WIDTH-16){half_c[15]}}, half_c};
      end
      3'b010: begin
        illegal_c = illegal_c | (|off_c);
        st_be_c   = '1;
        load_c    = rword_c;
      end
      3'b100: begin
        illegal_c = illegal_c | we_q;
        load_c    = {{(WIDTH-8){1'b0}}, byte_c};
      end
      3'b101: begin
        illegal_c = illegal_c | we_q | addr_q[0];
        load_c    = {{(WIDTH-16){1'b0}}, half_c};
      end
      default: illegal_c = 1'b1;
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [NLANE-1:0] par_q [DEPTH];
  logic [NLANE-1:0] wpar_c;
  logic [NLANE-1:0] rpar_c;
  logic             perr_q, perr_d;

  always_comb begin
    wpar_c = '0;
    rpar_c = '0;
    for (int l = 0; l < NLANE; l++) begin
      wpar_c[l] = ^mem_wd_c[8*l +: 8];
      rpar_c[l] = ^rword_c[8*l +: 8];
    end
  end

  // Parity bits follow the data lanes through every write, including the clear sweep
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int l = 0; l < NLANE; l++) begin
        if (mem_be_c[l]) par_q[mem_idx_c][l] <= wpar_c[l];
      end
    end
  end

  assign bus.perr = perr_q;
`endif

  // Next-state, write-port control and registered response
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_we_c  = 1'b0;
    mem_idx_c = ptr_q;
    mem_be_c  = '0;
    mem_wd_c  = '0;
`ifdef DMEM_PARITY_EN
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_CLEAR: begin
        mem_we_c = ~rst;
        mem_be_c = '1;
        if (ptr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
        else                         ptr_d   = ptr_q + AW'(1);
      end
      S_IDLE: begin
        if (bus.req && ready_q) begin
          we_d    = bus.we;
          size_d  = bus.size;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CW'(LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (illegal_c) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (we_q) begin
            mem_we_c  = ~rst;
            mem_idx_c = idx_c;
            mem_be_c  = st_be_c;
            mem_wd_c  = st_wd_c;
          end else begin
            rdata_d = load_c;
`ifdef DMEM_PARITY_EN
            perr_d  = rpar_c != par_q[idx_c];
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DMEM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Storage array: byte-lane write enables, no reset (cleared by the sweep)
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int l = 0; l < NLANE; l++) begin
        if (mem_be_c[l]) mem_q[mem_idx_c][8*l +: 8] <= mem_wd_c[8*l +: 8];
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;

endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised successor to the single-cycle data memory used by the multi-cycle CPU.
- Word-organised RAM with a req/ready/done handshake, configurable access latency, byte/half/word loads and stores, sign/zero extension, and error reporting for misaligned or out-of-range accesses.
- Clears memory after reset with a sequential sweep instead of a parallel reset.
- Sits between the multi-cycle control FSM and the datapath's memory data register.

Parameters:
- WIDTH, 32, data word width in bits; must be 32 (byte lanes are fixed at 4).
- DEPTH, 128, number of words; AW = $clog2(DEPTH).
- LAT, 2, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  1  access request; accepted when req && ready
- we  in  1  1 = store, 0 = load; sampled at acceptance
- size  in  3  funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  in  WIDTH  byte address; sampled at acceptance
- wdata  in  WIDTH  store data; the low bytes are used per size; sampled at acceptance
- ready  out  1  block idle and able to accept
- done  out  1  one-cycle pulse when the access completes
- rdata  out  WIDTH  load result; valid while done=1 and held until the next done
- err  out  1  one-cycle pulse coincident with done on an illegal access

Behaviour:
- Reset:
  - Reset is synchronous and active-high: rst sampled high at a clk edge resets the block.
  - On reset: state = CLEAR, clear pointer = 0, ready = 0, done = 0, err = 0, rdata = 0.
  - Reset asserted mid-access aborts that access with no write and no done, then restarts CLEAR.
- CLEAR state:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After ptr = DEPTH-1 is written, moves to IDLE; ready = 1 from the next cycle.
  - CLEAR lasts DEPTH cycles. req is ignored throughout.
- IDLE state:
  - ready = 1.
  - On req: latch we, size, addr and wdata; load the latency counter with LAT-1; go to BUSY; ready = 0 in the next cycle.
- BUSY state:
  - Counter decrements each cycle. When it reaches 0, the access completes that cycle: done = 1, state returns to IDLE, and ready = 1 in the following cycle.
  - Done therefore occurs LAT cycles after the acceptance edge. Back-to-back throughput is one access per LAT+1 cycles.
- Address decode:
  - Word index = addr[AW+1:2]; byte offset = addr[1:0].
- Error conditions (any one raises err):
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - addr[WIDTH-1:AW+2] != 0, i.e. out of range.
  - Unused size code: 011, 110 or 111, and 1xx on a store.
  - Effect: err = 1 together with done, no memory write, rdata = 0.
- Store commit:
  - Occurs on the done edge only.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes. Unwritten lanes keep their value.
- Load:
  - The selected word is read at the done edge and the lane is extracted.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
  - rdata is registered and holds until the next done.
- Inputs while BUSY: req, addr and wdata are ignored; there is no queueing.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit per byte lane (4 bits), written on store and on clear.
  - Every load checks parity over all 4 lanes of the addressed word.
  - A mismatch sets perr = 1 together with done. perr is an extra output port, 1 bit, reset 0.
  - rdata is still returned unchanged.
- When not defined: no parity storage and no perr port; the behaviour is otherwise identical.

Test Plan:
- Reset then idle: assert rst for 1 cycle, DEPTH=128 -> ready=0 for 128 cycles, then ready=1; LW of addr 0x1FC returns 0x00000000.
- Store and load, LAT=2: SW addr 0x10 wdata 0xDEADBEEF accepted at cycle t -> done at t+2; then LW 0x10 -> rdata 0xDEADBEEF. Next request must not be accepted before cycle t+3.
- Sub-word access: after the word above, SB addr 0x11 wdata 0x7F -> LW 0x10 = 0xDEAD7FEF. LB 0x13 = 0xFFFFFFDE. LBU 0x13 = 0x000000DE. LH 0x12 = 0xFFFFDEAD. LHU 0x12 = 0x0000DEAD.
- Errors: LW 0x12 -> done=1, err=1, rdata=0. SH 0x11 -> err=1 and word 0x10 unchanged. LW 0x200 with DEPTH=128 -> err=1. Size 011 -> err=1.
- Reset mid-access: SW 0x20 wdata 0x12345678 accepted, rst asserted the next cycle -> no done pulse, CLEAR reruns, LW 0x20 = 0.
- LAT sweep: LAT=1 and LAT=15 -> done exactly LAT cycles after acceptance, and req held high while BUSY is ignored.
